// File: rtl/uart_axil_pkg.sv
// Shared opcodes, status codes and FSM state type for the UART-to-AXI-Lite
// command engine.
package uart_axil_pkg;

  localparam logic [7:0] OP_WRITE    = 8'h01;
  localparam logic [7:0] OP_READ     = 8'h02;
  localparam logic [3:0] STAT_PREFIX = 4'hA;
  localparam logic [7:0] STAT_BAD_OP = 8'hEE;

  localparam int RESP_LEN = 5;
  localparam int LEN_W    = 3;

  typedef enum logic [2:0] {
    IDLE,
    CMD_ADDR,
    CMD_DATA,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    SEND
  } state_e;

  // Byte 0 is transmitted first.
  typedef logic [RESP_LEN-1:0][7:0] resp_buf_t;

  function automatic logic [7:0] status_byte(input logic [1:0] resp);
    return {STAT_PREFIX, 2'b00, resp};
  endfunction

endpackage

// File: rtl/uart_axil_resp_tx.sv
// Response buffer plus byte serializer: load captures up to RESP_LEN bytes,
// which are then presented one at a time on out_byte/out_valid.
module uart_axil_resp_tx
  import uart_axil_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LEN_W-1:0] len,
  input  resp_buf_t        data,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             done
);

  resp_buf_t        resp_buf;
  logic [LEN_W-1:0] idx;
  logic [LEN_W-1:0] last;
  logic             active;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_buf <= '0;
      idx      <= '0;
      last     <= '0;
      active   <= 1'b0;
    end else if (load) begin
      resp_buf <= data;
      idx      <= '0;
      last     <= len - LEN_W'(1);
      active   <= 1'b1;
    end else if (active && out_ready) begin
      if (idx == last) begin
        active <= 1'b0;
      end else begin
        idx <= idx + LEN_W'(1);
      end
    end
  end

  // out_byte only moves on a handshake, so it is stable while stalled.
  assign out_valid = active;
  assign out_byte  = resp_buf[idx];
  assign done      = active && out_ready && (idx == last);

endmodule

// File: rtl/uart_axil_master.sv
// Command engine: parses framed bytes into AXI-Lite single-beat reads and
// writes and serialises the status/read data back as response bytes.
module uart_axil_master
  import uart_axil_pkg::*;
#(
  parameter int ADDR_W        = 5,
  parameter int FRAME_TIMEOUT = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] m_axil_awaddr,
  output logic [2:0]        m_axil_awprot,
  output logic              m_axil_awvalid,
  input  logic              m_axil_awready,
  output logic [31:0]       m_axil_wdata,
  output logic [3:0]        m_axil_wstrb,
  output logic              m_axil_wvalid,
  input  logic              m_axil_wready,
  input  logic [1:0]        m_axil_bresp,
  input  logic              m_axil_bvalid,
  output logic              m_axil_bready,
  output logic [ADDR_W-1:0] m_axil_araddr,
  output logic [2:0]        m_axil_arprot,
  output logic              m_axil_arvalid,
  input  logic              m_axil_arready,
  input  logic [31:0]       m_axil_rdata,
  input  logic [1:0]        m_axil_rresp,
  input  logic              m_axil_rvalid,
  output logic              m_axil_rready,
  output logic              busy,
  output logic              err_opcode,
  output logic              err_timeout
);

  localparam int               TMO_W    = (FRAME_TIMEOUT > 1) ? $clog2(FRAME_TIMEOUT) : 1;
  localparam bit               TMO_EN   = (FRAME_TIMEOUT != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FRAME_TIMEOUT - 1);

  state_e              state, state_d;
  logic                is_write;
  logic [1:0]          byte_cnt;
  logic [ADDR_W-1:0]   addr_sr;
  logic [31:0]         data_sr;
  logic                aw_done, w_done;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                tmo_hit;
  logic                in_fire, aw_hs, w_hs;
  logic                resp_load, resp_done;
  logic [LEN_W-1:0]    resp_len;
  resp_buf_t           resp_data;
  logic                opcode_bad, tmo_expire;

  // Every channel transfers on the cycle where valid && ready; valids are
  // driven from state only and never look at the matching ready.
  assign in_ready       = (state == IDLE) || (state == CMD_ADDR) || (state == CMD_DATA);
  assign in_fire        = in_valid && in_ready;
  assign m_axil_awvalid = (state == WR_REQ) && !aw_done;
  assign m_axil_wvalid  = (state == WR_REQ) && !w_done;
  assign m_axil_bready  = (state == WR_RESP);
  assign m_axil_arvalid = (state == RD_REQ);
  assign m_axil_rready  = (state == RD_RESP);
  assign aw_hs          = m_axil_awvalid && m_axil_awready;
  assign w_hs           = m_axil_wvalid && m_axil_wready;
  assign m_axil_awaddr  = addr_sr;
  assign m_axil_araddr  = addr_sr;
  assign m_axil_wdata   = data_sr;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_wstrb   = 4'hF;
  assign busy           = (state != IDLE);
  assign tmo_hit        = TMO_EN && (tmo_cnt == TMO_LAST);

  always_comb begin
    state_d    = state;
    resp_load  = 1'b0;
    resp_len   = '0;
    resp_data  = '0;
    opcode_bad = 1'b0;
    tmo_expire = 1'b0;
    case (state)
      IDLE: begin
        if (in_fire) begin
          if (in_byte == OP_WRITE || in_byte == OP_READ) begin
            state_d = CMD_ADDR;
          end else begin
            state_d      = SEND;
            resp_load    = 1'b1;
            resp_len     = LEN_W'(1);
            resp_data[0] = STAT_BAD_OP;
            opcode_bad   = 1'b1;
          end
        end
      end
      CMD_ADDR, CMD_DATA: begin
        // An accepted byte always beats a timeout expiring in the same cycle.
        if (in_fire) begin
          if (byte_cnt == 2'd3) begin
            if (state == CMD_DATA)  state_d = WR_REQ;
            else if (is_write)      state_d = CMD_DATA;
            else                    state_d = RD_REQ;
          end
        end else if (tmo_hit) begin
          state_d    = IDLE;
          tmo_expire = 1'b1;
        end
      end
      WR_REQ: begin
        if ((aw_done || aw_hs) && (w_done || w_hs)) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (m_axil_bvalid) begin
          state_d      = SEND;
          resp_load    = 1'b1;
          resp_len     = LEN_W'(1);
          resp_data[0] = status_byte(m_axil_bresp);
        end
      end
      RD_REQ: begin
        if (m_axil_arready) state_d = RD_RESP;
      end
      RD_RESP: begin
        if (m_axil_rvalid) begin
          state_d      = SEND;
          resp_load    = 1'b1;
          resp_len     = LEN_W'(RESP_LEN);
          resp_data[0] = status_byte(m_axil_rresp);
          resp_data[1] = m_axil_rdata[31:24];
          resp_data[2] = m_axil_rdata[23:16];
          resp_data[3] = m_axil_rdata[15:8];
          resp_data[4] = m_axil_rdata[7:0];
        end
      end
      SEND: begin
        if (resp_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      is_write    <= 1'b0;
      byte_cnt    <= '0;
      addr_sr     <= '0;
      data_sr     <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      tmo_cnt     <= '0;
      err_opcode  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_d;
      err_opcode  <= opcode_bad;
      err_timeout <= tmo_expire;

      if (in_fire) begin
        if (state == IDLE) begin
          is_write <= (in_byte == OP_WRITE);
          byte_cnt <= '0;
        end else begin
          byte_cnt <= byte_cnt + 2'd1;
          if (state == CMD_ADDR) addr_sr <= ADDR_W'({addr_sr, in_byte});
          else                   data_sr <= {data_sr[23:0], in_byte};
        end
      end

      if (TMO_EN && (state == CMD_ADDR || state == CMD_DATA) && !in_fire && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end else begin
        tmo_cnt <= '0;
      end

      if (state == WR_REQ) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

  uart_axil_resp_tx u_resp_tx (
    .clk       (clk),
    .reset     (reset),
    .load      (resp_load),
    .len       (resp_len),
    .data      (resp_data),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done      (resp_done)
  );

endmodule

// File: tb/tb_uart_axil_master.sv
// Bench for uart_axil_master: directed frames plus randomized commands checked
// against a frame-level model with expected-byte and expected-request queues.
module tb_uart_axil_master;

  localparam int ADDR_W = 5;
  localparam int FT     = 20;

  logic              clk, reset;
  logic [7:0]        in_byte;
  logic              in_valid, in_ready;
  logic [7:0]        out_byte;
  logic              out_valid, out_ready;
  logic [ADDR_W-1:0] m_axil_awaddr, m_axil_araddr;
  logic [2:0]        m_axil_awprot, m_axil_arprot;
  logic              m_axil_awvalid, m_axil_awready;
  logic [31:0]       m_axil_wdata, m_axil_rdata;
  logic [3:0]        m_axil_wstrb;
  logic              m_axil_wvalid, m_axil_wready;
  logic [1:0]        m_axil_bresp, m_axil_rresp;
  logic              m_axil_bvalid, m_axil_bready;
  logic              m_axil_arvalid, m_axil_arready;
  logic              m_axil_rvalid, m_axil_rready;
  logic              busy, err_opcode, err_timeout;

  uart_axil_master #(.ADDR_W(ADDR_W), .FRAME_TIMEOUT(FT)) dut (
    .clk(clk), .reset(reset),
    .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
    .busy(busy), .err_opcode(err_opcode), .err_timeout(err_timeout)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;

  logic [7:0]        exp_q[$];
  logic [ADDR_W-1:0] exp_aw_q[$];
  logic [ADDR_W-1:0] exp_ar_q[$];
  logic [31:0]       exp_w_q[$];
  logic [1:0]        b_resp_q[$];
  logic [33:0]       r_q[$];

  int  aw_lat = 0, w_lat = 0, ar_lat = 0, b_lat = 0, r_lat = 0;
  int  aw_cnt = 0, ar_cnt = 0;
  int  opc_seen = 0, tmo_seen = 0, exp_opc = 0, exp_tmo = 0;
  int  out_stall = 0;
  bit  rand_out = 0;
  bit  aw_seen = 0, w_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // ---------------- AXI-Lite slave model ----------------
  initial begin : aw_slave
    int waited;
    waited = 0;
    m_axil_awready = 1'b0;
    forever begin
      @(negedge clk);
      if (reset || !m_axil_awvalid) begin
        m_axil_awready = 1'b0;
        waited = 0;
      end else if (waited >= aw_lat) begin
        m_axil_awready = 1'b1;
        check("aw_expected", 32'(exp_aw_q.size() > 0), 1);
        if (exp_aw_q.size() > 0) check("awaddr", 32'(m_axil_awaddr), 32'(exp_aw_q.pop_front()));
        check("awprot", 32'(m_axil_awprot), 0);
        aw_seen = 1;
        aw_cnt++;
        waited = 0;
      end else begin
        m_axil_awready = 1'b0;
        waited++;
      end
    end
  end

  initial begin : w_slave
    int waited;
    waited = 0;
    m_axil_wready = 1'b0;
    forever begin
      @(negedge clk);
      if (reset || !m_axil_wvalid) begin
        m_axil_wready = 1'b0;
        waited = 0;
      end else if (waited >= w_lat) begin
        m_axil_wready = 1'b1;
        check("w_expected", 32'(exp_w_q.size() > 0), 1);
        if (exp_w_q.size() > 0) check("wdata", m_axil_wdata, exp_w_q.pop_front());
        check("wstrb", 32'(m_axil_wstrb), 32'hF);
        w_seen = 1;
        waited = 0;
      end else begin
        m_axil_wready = 1'b0;
        waited++;
      end
    end
  end

  initial begin : ar_slave
    int waited;
    waited = 0;
    m_axil_arready = 1'b0;
    forever begin
      @(negedge clk);
      if (reset || !m_axil_arvalid) begin
        m_axil_arready = 1'b0;
        waited = 0;
      end else if (waited >= ar_lat) begin
        m_axil_arready = 1'b1;
        check("ar_expected", 32'(exp_ar_q.size() > 0), 1);
        if (exp_ar_q.size() > 0) check("araddr", 32'(m_axil_araddr), 32'(exp_ar_q.pop_front()));
        check("arprot", 32'(m_axil_arprot), 0);
        ar_cnt++;
        waited = 0;
      end else begin
        m_axil_arready = 1'b0;
        waited++;
      end
    end
  end

  initial begin : b_slave
    int waited;
    bit first;
    waited = 0;
    first = 1;
    m_axil_bvalid = 1'b0;
    m_axil_bresp  = 2'b00;
    forever begin
      @(negedge clk);
      if (reset || !m_axil_bready) begin
        m_axil_bvalid = 1'b0;
        waited = 0;
        first = 1;
      end else if (!m_axil_bvalid) begin
        if (first) begin
          check("bready_after_aw_w", 32'({aw_seen, w_seen}), 32'b11);
          first = 0;
        end
        if (waited >= b_lat) begin
          m_axil_bresp  = (b_resp_q.size() > 0) ? b_resp_q.pop_front() : 2'b00;
          m_axil_bvalid = 1'b1;
          aw_seen = 0;
          w_seen  = 0;
          waited  = 0;
        end else begin
          waited++;
        end
      end
    end
  end

  initial begin : r_slave
    int waited;
    logic [33:0] rv;
    waited = 0;
    m_axil_rvalid = 1'b0;
    m_axil_rdata  = '0;
    m_axil_rresp  = 2'b00;
    forever begin
      @(negedge clk);
      if (reset || !m_axil_rready) begin
        m_axil_rvalid = 1'b0;
        waited = 0;
      end else if (!m_axil_rvalid) begin
        if (waited >= r_lat) begin
          rv = (r_q.size() > 0) ? r_q.pop_front() : '0;
          {m_axil_rresp, m_axil_rdata} = rv;
          m_axil_rvalid = 1'b1;
          waited = 0;
        end else begin
          waited++;
        end
      end
    end
  end

  // ---------------- response sink and error-pulse monitor ----------------
  initial begin : out_sink
    logic [7:0] prev_byte;
    bit prev_stalled;
    prev_byte = '0;
    prev_stalled = 0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        out_ready = 1'b0;
        prev_stalled = 0;
      end else begin
        if (prev_stalled) check("out_hold", 32'({out_valid, out_byte}), 32'({1'b1, prev_byte}));
        if (out_valid && out_stall > 0) begin
          out_ready = 1'b0;
          out_stall--;
        end else begin
          out_ready = rand_out ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (out_valid && out_ready) begin
          check("out_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) check("out_byte", 32'(out_byte), 32'(exp_q.pop_front()));
        end
        prev_stalled = out_valid && !out_ready;
        prev_byte = out_byte;
      end
    end
  end

  initial begin : pulse_mon
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (err_opcode)  opc_seen++;
        if (err_timeout) tmo_seen++;
      end
    end
  end

  // ---------------- driver tasks and frame-level model ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit taken;
    taken = 0;
    in_byte  = b;
    in_valid = 1'b1;
    for (int k = 0; k < 500 && !taken; k++) begin
      @(negedge clk);
      if (in_ready) taken = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!taken) check("in_accept", 32'(in_ready), 1);
  endtask

  task automatic send_frame(input logic [7:0] fr[], input int gap);
    foreach (fr[i]) begin
      if (gap > 0) idle($urandom_range(0, gap));
      send_byte(fr[i]);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] resp, input int gap);
    logic [7:0] fr[];
    fr = new[9];
    fr = '{8'h01, addr[31:24], addr[23:16], addr[15:8], addr[7:0],
           data[31:24], data[23:16], data[15:8], data[7:0]};
    exp_aw_q.push_back(addr[ADDR_W-1:0]);
    exp_w_q.push_back(data);
    b_resp_q.push_back(resp);
    exp_q.push_back({4'hA, 2'b00, resp});
    send_frame(fr, gap);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] resp, input int gap);
    logic [7:0] fr[];
    fr = new[5];
    fr = '{8'h02, addr[31:24], addr[23:16], addr[15:8], addr[7:0]};
    exp_ar_q.push_back(addr[ADDR_W-1:0]);
    r_q.push_back({resp, data});
    exp_q.push_back({4'hA, 2'b00, resp});
    exp_q.push_back(data[31:24]);
    exp_q.push_back(data[23:16]);
    exp_q.push_back(data[15:8]);
    exp_q.push_back(data[7:0]);
    send_frame(fr, gap);
  endtask

  task automatic do_bad(input logic [7:0] op);
    exp_q.push_back(8'hEE);
    exp_opc++;
    send_byte(op);
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while ((busy || exp_q.size() != 0) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_idle"}, 32'(busy), 0);
    check({tag, "_drained"}, 32'(exp_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int a0, r0;
    logic [7:0] bop;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_byte  = '0;

    repeat (3) @(negedge clk);
    check("rst_in_ready",  32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_byte",  32'(out_byte), 0);
    check("rst_valids",    32'({m_axil_awvalid, m_axil_wvalid, m_axil_arvalid}), 0);
    check("rst_readies",   32'({m_axil_bready, m_axil_rready}), 0);
    check("rst_addr_data", 32'({m_axil_awaddr, m_axil_araddr}) | m_axil_wdata, 0);
    check("rst_busy_err",  32'({busy, err_opcode, err_timeout}), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    do_write(32'h0000_0010, 32'h0000_0041, 2'd0, 0);
    wait_done("wr_basic");
    do_read(32'h0000_0000, 32'h0000_3003, 2'd0, 0);
    wait_done("rd_basic");
    do_read(32'h0000_0004, 32'hDEAD_BEEF, 2'd2, 0);
    wait_done("rd_slverr");

    a0 = aw_cnt;
    r0 = ar_cnt;
    do_bad(8'h7F);
    wait_done("bad_op");
    check("bad_op_no_axi", 32'(aw_cnt - a0 + ar_cnt - r0), 0);
    check("bad_op_pulses", 32'(opc_seen), 32'(exp_opc));
    do_read(32'h0000_0008, 32'h0102_0304, 2'd0, 0);
    wait_done("after_bad");

    // Partial frame left idle for FT cycles is dropped.
    send_byte(8'h01);
    send_byte(8'h00);
    idle(FT - 1);
    @(negedge clk);
    check("tmo_still_busy", 32'(busy), 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("tmo_idle", 32'(busy), 0);
    check("tmo_in_ready", 32'(in_ready), 1);
    check("tmo_no_resp", 32'(out_valid), 0);
    exp_tmo++;
    @(negedge clk);
    check("tmo_pulses", 32'(tmo_seen), 32'(exp_tmo));
    @(posedge clk);
    #1;

    // A byte landing in the expiry cycle keeps the frame alive.
    exp_aw_q.push_back(5'h10);
    exp_w_q.push_back(32'h0000_0077);
    b_resp_q.push_back(2'd0);
    exp_q.push_back(8'hA0);
    send_byte(8'h01);
    send_byte(8'h00);
    idle(FT - 1);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h77);
    wait_done("tmo_rescue");
    check("tmo_rescue_pulses", 32'(tmo_seen), 32'(exp_tmo));

    // Address channel stalled, data channel immediate.
    aw_lat = 5;
    w_lat  = 0;
    do_write(32'h0000_0008, 32'h0000_CAFE, 2'd1, 0);
    @(negedge clk);
    check("stall_both_valid", 32'({m_axil_awvalid, m_axil_wvalid}), 32'b11);
    @(negedge clk);
    check("stall_w_dropped", 32'({m_axil_awvalid, m_axil_wvalid, m_axil_bready}), 32'b100);
    wait_done("stall_wr");
    aw_lat = 0;

    // Response consumer stalled for 10 cycles.
    out_stall = 10;
    do_read(32'h0000_001C, 32'h1234_5678, 2'd1, 0);
    wait_done("out_stall");

    // Reset while the write request is outstanding.
    aw_lat = 60;
    w_lat  = 60;
    do_write(32'h0000_0003, 32'h0000_0055, 2'd0, 0);
    @(negedge clk);
    check("rst_mid_pre", 32'(m_axil_awvalid), 1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_valids", 32'({m_axil_awvalid, m_axil_wvalid, m_axil_arvalid}), 0);
    check("rst_mid_busy", 32'(busy), 0);
    exp_q.delete();
    exp_aw_q.delete();
    exp_w_q.delete();
    b_resp_q.delete();
    aw_seen = 0;
    w_seen  = 0;
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
    aw_lat = 0;
    w_lat  = 0;
    @(posedge clk);
    #1;
    check("rst_mid_in_ready", 32'(in_ready), 1);
    do_write(32'h0000_001F, 32'hA5A5_5A5A, 2'd3, 0);
    wait_done("after_reset");

    // Randomized command mix with random latencies, gaps and backpressure.
    rand_out = 1;
    for (int n = 0; n < 30; n++) begin
      aw_lat = $urandom_range(0, 3);
      w_lat  = $urandom_range(0, 3);
      ar_lat = $urandom_range(0, 3);
      b_lat  = $urandom_range(0, 3);
      r_lat  = $urandom_range(0, 3);
      case ($urandom_range(0, 5))
        0, 1, 2: do_write($urandom, $urandom, 2'($urandom_range(0, 3)), 3);
        3, 4:    do_read($urandom, $urandom, 2'($urandom_range(0, 3)), 3);
        default: begin
          bop = 8'($urandom_range(0, 255));
          while (bop == 8'h01 || bop == 8'h02) bop = 8'($urandom_range(0, 255));
          do_bad(bop);
        end
      endcase
      wait_done("rand");
    end

    check("final_opc_pulses", 32'(opc_seen), 32'(exp_opc));
    check("final_tmo_pulses", 32'(tmo_seen), 32'(exp_tmo));
    check("final_req_queues", 32'(exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
